branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
//   Direct-mapped table of 2-bit saturating counters that replaces the single-counter
//   branch predictor. Looked up in ID with the IF_ID PC to give the taken/not-taken guess.
//   Trained from EX with the resolved outcome. Flags mispredictions, which drive IF_ID flush.
// PARAMETERS
//   IDX_BITS    4      table index width; entries = 2**IDX_BITS
//   INIT_STATE  2'b11  counter value loaded into every entry on reset (strongly taken)
// PORTS
//   clk_i            in   1         clock, all state updates on posedge
//   rst_i            in   1         synchronous reset, active-high
//   lookup_valid_i   in   1         ID holds a conditional branch
//   lookup_pc_i      in   32        PC of the branch in ID
//   predict_o        out  1         1 = predict taken (0 when lookup_valid_i = 0)
//   predict_idx_o    out  IDX_BITS  index used for lookup; carried down pipeline
//   update_valid_i   in   1         EX resolves a conditional branch this cycle
//   update_idx_i     in   IDX_BITS  predict_idx_o carried with the branch to EX
//   update_pred_i    in   1         predict_o carried with the branch to EX
//   update_taken_i   in   1         resolved outcome from ALU compare
//   mispredict_o     out  1         update_valid_i & (update_pred_i != update_taken_i)
// BEHAVIOUR
//   - Storage: cnt[0 .. 2**IDX_BITS-1], 2 bits each; states 00 SNT, 01 WNT, 10 WT, 11 ST.
//   - Lookup, combinational, 0 cycles:
//     - idx = lookup_pc_i[IDX_BITS+1:2].
//     - predict_o = lookup_valid_i & cnt[idx][1].
//     - predict_idx_o = idx regardless of lookup_valid_i.
//   - Update, 1 cycle: on posedge with update_valid_i = 1:
//     - taken: cnt[update_idx_i] += 1, saturating at 11.
//     - not taken: cnt[update_idx_i] -= 1, saturating at 00. Never wraps.
//   - mispredict_o is combinational, same cycle as update_valid_i. No registered output.
//   - Lookup and update to the same index in the same cycle:
//     - predict_o shows the pre-update value (no bypass).
//     - The new value is visible from the next cycle.
//   - update_valid_i = 0: table unchanged; update_idx_i, update_pred_i, update_taken_i ignored.
//   - Reset, synchronous, takes priority over update:
//     - every entry <= INIT_STATE, GHR <= 0.
//     - Outputs are combinational from inputs and state, so predict_o = INIT_STATE[1] & lookup_valid_i
//       and mispredict_o follows its inputs.
//   - Reset mid-operation: any update in the reset cycle is discarded.
//   - Lookup PC bits [1:0] and bits above IDX_BITS+1 are ignored (aliasing is allowed).
// CONFIGURATION
//   GSHARE_EN defined:
//     - Adds global history register ghr[IDX_BITS-1:0], reset 0.
//     - Lookup idx = lookup_pc_i[IDX_BITS+1:2] ^ ghr.
//     - On update_valid_i: ghr <= {ghr[IDX_BITS-2:0], update_taken_i}.
//     - Training always uses update_idx_i, never a recomputed index.
//   GSHARE_EN undefined: no ghr; bimodal PC indexing only. Ports identical in both builds.
// TESTING (IDX_BITS=4, INIT_STATE=2'b11)
//   1 Reset, then lookup_valid_i=1, pc=0x40 -> predict_idx_o=0, predict_o=1, mispredict_o=0.
//   2 Two updates to idx 0, taken=0, pred=1 -> mispredict_o=1 both cycles; cnt[0]=01; predict_o=0 for pc 0x40.
//   3 Five not-taken updates to idx 3 -> cnt[3]=00, no wrap; five taken -> 11, no wrap.
//   4 Same cycle: lookup pc 0x48 (idx 2, cnt=10) plus not-taken update idx 2 -> predict_o=1; next cycle predict_o=0.
//   5 Drive idx 5 to 00, assert rst_i one cycle alongside a taken update -> cnt[5]=11, update discarded.
//   6 GSHARE_EN: from reset, updates T,N,T -> ghr=4'b0101; lookup pc 0x40 -> predict_idx_o=5.

Source files
------------

// File: rtl/branch_history_table_if.sv
// ---------------------------------------------------------------------------
// branch_history_table_if
//   Groups the branch-predictor lookup (ID stage) and training (EX stage)
//   signals into one bundle.
//
//   Lookup side : lookup_valid_i, lookup_pc_i  -> predict_o, predict_idx_o
//   Update side : update_valid_i, update_idx_i, update_pred_i, update_taken_i
//                 -> mispredict_o
//
//   Modports
//     master : the pipeline, which drives the *_i signals and observes the *_o signals
//     slave  : the predictor table, the reverse of master
// ---------------------------------------------------------------------------
interface branch_history_table_if #(
  parameter int IDX_BITS = 4
);
  logic                lookup_valid_i;
  logic [31:0]         lookup_pc_i;
  logic                predict_o;
  logic [IDX_BITS-1:0] predict_idx_o;
  logic                update_valid_i;
  logic [IDX_BITS-1:0] update_idx_i;
  logic                update_pred_i;
  logic                update_taken_i;
  logic                mispredict_o;

  modport master (
    output lookup_valid_i, lookup_pc_i,
    output update_valid_i, update_idx_i, update_pred_i, update_taken_i,
    input  predict_o, predict_idx_o, mispredict_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    input  update_valid_i, update_idx_i, update_pred_i, update_taken_i,
    output predict_o, predict_idx_o, mispredict_o
  );
endinterface

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//   Direct-mapped table of 2-bit saturating counters used as the branch
//   predictor. The table is looked up combinationally in ID with the IF_ID PC
//   and trained one cycle later from EX with the resolved outcome.
//   Mispredictions are flagged combinationally so that they can drive the
//   IF_ID flush.
//
//   Counter states: 00 strongly not-taken, 01 weakly not-taken,
//                   10 weakly taken,       11 strongly taken.
//
//   Parameters
//     IDX_BITS   : table index width; the table has 2**IDX_BITS entries
//     INIT_STATE : value loaded into every counter on reset
//
//   Ports
//     clk_i : clock; all state updates happen on its rising edge
//     rst_i : synchronous reset, active-high; takes priority over training
//     bus   : lookup and update bundle (slave modport)
//
//   Build option
//     GSHARE_EN : when defined, a global history register of the last
//                 IDX_BITS resolved outcomes is XORed into the lookup index.
//                 The ports are the same in both builds.
// ---------------------------------------------------------------------------
module branch_history_table #(
  parameter int         IDX_BITS   = 4,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input logic                    clk_i,
  input logic                    rst_i,
  branch_history_table_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          r_cnt [ENTRIES];
  logic [IDX_BITS-1:0] w_pc_idx;
  logic [IDX_BITS-1:0] w_lookup_idx;
  logic [1:0]          w_cnt_cur;
  logic [1:0]          w_cnt_next;

  // PC bits [1:0] and the bits above the index are deliberately dropped, so
  // branches whose PCs share bits [IDX_BITS+1:2] alias onto the same counter.
  logic w_unused_pc;
  assign w_unused_pc = ^{bus.lookup_pc_i[31:IDX_BITS+2], bus.lookup_pc_i[1:0]};
  assign w_pc_idx    = bus.lookup_pc_i[IDX_BITS+1:2];

`ifdef GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;

  assign w_lookup_idx = w_pc_idx ^ r_ghr;

  // The history shifts on every resolved branch. Training uses the index that
  // was carried down the pipeline, not one recomputed from this history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ghr <= '0;
    end else if (bus.update_valid_i) begin
      r_ghr <= {r_ghr[IDX_BITS-2:0], bus.update_taken_i};
    end
  end
`else
  assign w_lookup_idx = w_pc_idx;
`endif

  // Lookup reads the stored value directly. A same-cycle update to the same
  // entry is therefore seen only from the next cycle (no bypass).
  assign bus.predict_idx_o = w_lookup_idx;
  assign bus.predict_o     = bus.lookup_valid_i & r_cnt[w_lookup_idx][1];
  assign bus.mispredict_o  = bus.update_valid_i & (bus.update_pred_i != bus.update_taken_i);

  // Saturating increment or decrement of the entry being trained.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path
    // leaves it unassigned and infers a latch.
    w_cnt_cur  = r_cnt[bus.update_idx_i];
    w_cnt_next = w_cnt_cur;
    if (bus.update_taken_i) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: this table is reset entry by entry because the predictor must
      // start from a known bias. Storage arrays that need no defined start
      // value should be left without a reset so they can map onto RAM.
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= INIT_STATE;
      end
    end else if (bus.update_valid_i) begin
      // NOTE: sequential state is written with non-blocking assignments, so
      // every reader in this cycle sees the value from before the clock edge.
      r_cnt[bus.update_idx_i] <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// ---------------------------------------------------------------------------
// tb_branch_history_table
//   Directed self-checking bench for branch_history_table with IDX_BITS=4 and
//   INIT_STATE=2'b11. Inputs change 1 time unit after a rising edge, and the
//   outputs are compared once they have settled, well before the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_history_table;

  localparam int IDX_BITS = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  branch_history_table_if #(.IDX_BITS(IDX_BITS)) bus ();

  branch_history_table #(.IDX_BITS(IDX_BITS), .INIT_STATE(2'b11)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lookup_valid_i = 1'b1;
    bus.lookup_pc_i    = pc;
    #1;
  endtask

  // Drive an update for one clock edge, then drop update_valid_i.
  task automatic train(input logic [3:0] idx, input logic taken, input logic pred);
    bus.update_valid_i = 1'b1;
    bus.update_idx_i   = idx;
    bus.update_taken_i = taken;
    bus.update_pred_i  = pred;
    tick();
    bus.update_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i              = 1'b1;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_pc_i    = '0;
    bus.update_valid_i = 1'b0;
    bus.update_idx_i   = '0;
    bus.update_pred_i  = 1'b0;
    bus.update_taken_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    // 1: state after reset; every counter is strongly taken.
    lookup(32'h40);
    check("reset_idx",  32'(bus.predict_idx_o), 32'd0);
    check("reset_pred", 32'(bus.predict_o),     32'd1);
    check("reset_misp", 32'(bus.mispredict_o),  32'd0);
    bus.lookup_valid_i = 1'b0;
    #1;
    check("pred_gated_by_valid", 32'(bus.predict_o), 32'd0);
    lookup(32'h7C);
    check("reset_idx15_pred", 32'(bus.predict_o), 32'd1);

    // 2: two mispredicted not-taken updates to idx 0, so 11 -> 10 -> 01.
    bus.update_valid_i = 1'b1;
    bus.update_idx_i   = 4'd0;
    bus.update_taken_i = 1'b0;
    bus.update_pred_i  = 1'b1;
    #1;
    check("misp_cycle1", 32'(bus.mispredict_o), 32'd1);
    tick();
    check("misp_cycle2", 32'(bus.mispredict_o), 32'd1);
    tick();
    bus.update_valid_i = 1'b0;
    #1;
    check("misp_drops_without_valid", 32'(bus.mispredict_o), 32'd0);
    lookup(32'h40);
    check("cnt0_01_pred", 32'(bus.predict_o), 32'd0);
    train(4'd0, 1'b1, 1'b0);                 // 01 -> 10
    check("cnt0_was_01", 32'(bus.predict_o), 32'd1);

    // 3: saturation at both ends for idx 3 (pc 0x4C).
    lookup(32'h4C);
    for (int i = 0; i < 5; i++) train(4'd3, 1'b0, 1'b0);
    check("cnt3_sat_low", 32'(bus.predict_o), 32'd0);
    bus.update_valid_i = 1'b1;
    bus.update_idx_i   = 4'd3;
    bus.update_taken_i = 1'b1;
    bus.update_pred_i  = 1'b1;
    #1;
    check("correct_pred_no_misp", 32'(bus.mispredict_o), 32'd0);
    bus.update_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) train(4'd3, 1'b1, 1'b0);
    check("cnt3_sat_high", 32'(bus.predict_o), 32'd1);
    train(4'd3, 1'b0, 1'b1);                 // 11 -> 10
    check("cnt3_one_down", 32'(bus.predict_o), 32'd1);

    // 4: same-cycle lookup and update of idx 2 (pc 0x48); no bypass.
    train(4'd2, 1'b0, 1'b1);                 // 11 -> 10
    lookup(32'h48);
    check("idx2_idx", 32'(bus.predict_idx_o), 32'd2);
    bus.update_valid_i = 1'b1;
    bus.update_idx_i   = 4'd2;
    bus.update_taken_i = 1'b0;
    bus.update_pred_i  = 1'b1;
    #1;
    check("same_cycle_old_value", 32'(bus.predict_o), 32'd1);
    tick();
    bus.update_valid_i = 1'b0;
    #1;
    check("next_cycle_new_value", 32'(bus.predict_o), 32'd0);

    // 5: reset beats a same-cycle taken update on idx 5 (pc 0x54).
    for (int i = 0; i < 3; i++) train(4'd5, 1'b0, 1'b1);
    lookup(32'h54);
    check("cnt5_low", 32'(bus.predict_o), 32'd0);
    rst_i              = 1'b1;
    bus.update_valid_i = 1'b1;
    bus.update_idx_i   = 4'd5;
    bus.update_taken_i = 1'b1;
    bus.update_pred_i  = 1'b0;
    tick();
    rst_i              = 1'b0;
    bus.update_valid_i = 1'b0;
    #1;
    check("cnt5_after_reset", 32'(bus.predict_o), 32'd1);
    train(4'd5, 1'b0, 1'b1);                 // 11 -> 10
    check("cnt5_reset_to_11", 32'(bus.predict_o), 32'd1);
    train(4'd5, 1'b0, 1'b1);                 // 10 -> 01
    check("cnt5_then_01", 32'(bus.predict_o), 32'd0);
    lookup(32'h48);
    check("cnt2_reset", 32'(bus.predict_o), 32'd1);

    // Only PC bits [5:2] select the entry.
    lookup(32'hFFFF_FFC3);
    check("alias_idx0", 32'(bus.predict_idx_o), 32'd0);
    lookup(32'h8000_0036);
    check("alias_idx13", 32'(bus.predict_idx_o), 32'd13);

    // 6: history after T,N,T from reset (training on idx 7).
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    train(4'd7, 1'b1, 1'b1);
    train(4'd7, 1'b0, 1'b1);
    train(4'd7, 1'b1, 1'b1);
    lookup(32'h40);
`ifdef GSHARE_EN
    check("gshare_idx", 32'(bus.predict_idx_o), 32'd5);
`else
    check("bimodal_idx", 32'(bus.predict_idx_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
